// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - upstream/downstream valid/ready handshake bundle for pipe_stage_buf
interface pipe_stage_buf_if #(
    parameter int DATA_W = 70
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry valid/ready skid buffer between pipeline stages
// Optional stall/bubble counters enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
    parameter int DATA_W = 70,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_accept;
    logic              w_pop;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_pop    = r_out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = bus.in_data;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_nxt  = bus.in_data;
                    end else if (w_accept) begin
                        w_state_nxt = S_TWO;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = '0;
                    end
                end
                S_TWO: begin
                    // skid is always older than anything upstream, so it refills main first
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != S_TWO);
            r_out_valid <= (w_state_nxt != S_EMPTY);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_out_valid && bus.out_ready && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed vector bench for pipe_stage_buf (counters follow PIPE_STAGE_BUF_PERF_EN)
module tb_pipe_stage_buf;

    localparam int DW = 70;

`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] stall_a;
    logic [31:0] bubble_a;
    logic [1:0]  stall_b;
    logic [1:0]  bubble_b;

    int n_cmp;
    int n_fail;
    int m_stall;
    int m_bubble;
    int m_stall2;
    int m_bubble2;
    logic prev_ov;

    pipe_stage_buf_if #(.DATA_W(DW)) bus_a ();
    pipe_stage_buf_if #(.DATA_W(DW)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.in_data   = bus_a.in_data;
    assign bus_b.out_ready = bus_a.out_ready;

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(32)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus_a.slave),
        .stall_cnt  (stall_a),
        .bubble_cnt (bubble_a)
    );

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus_b.slave),
        .stall_cnt  (stall_b),
        .bubble_cnt (bubble_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle; the counter model sees pre-edge valid/ready.
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic exp_ov);
        bus_a.in_valid  = iv;
        bus_a.in_data   = d;
        bus_a.out_ready = ordy;
        flush           = fl;
        if (prev_ov && !ordy) begin
            m_stall++;
            if (m_stall2 < 3) m_stall2++;
        end
        if (!prev_ov && ordy) begin
            m_bubble++;
            if (m_bubble2 < 3) m_bubble2++;
        end
        @(posedge clk);
        #1;
        prev_ov = exp_ov;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall32"},  DW'(stall_a),  PERF ? DW'(m_stall)   : '0);
        chk({tag, "_bubble32"}, DW'(bubble_a), PERF ? DW'(m_bubble)  : '0);
        chk({tag, "_stall2"},   DW'(stall_b),  PERF ? DW'(m_stall2)  : '0);
        chk({tag, "_bubble2"},  DW'(bubble_b), PERF ? DW'(m_bubble2) : '0);
    endtask

    vec_t tbl[21];

    initial begin
        n_cmp = 0; n_fail = 0;
        m_stall = 0; m_bubble = 0; m_stall2 = 0; m_bubble2 = 0;
        prev_ov = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b0, 1'b1, DW'(i + 1), 1'b1};
        end
        tbl[8]  = '{1'b0, DW'(0),    1'b1, 1'b0, 1'b0, DW'(0),    1'b1};
        tbl[9]  = '{1'b1, DW'('hA),  1'b1, 1'b0, 1'b1, DW'('hA),  1'b1};
        tbl[10] = '{1'b1, DW'('hB),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b0};
        tbl[11] = '{1'b1, DW'('hC),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b0};
        tbl[12] = '{1'b1, DW'('hC),  1'b1, 1'b0, 1'b1, DW'('hB),  1'b1};
        tbl[13] = '{1'b1, DW'('hC),  1'b1, 1'b0, 1'b1, DW'('hC),  1'b1};
        tbl[14] = '{1'b0, DW'(0),    1'b1, 1'b0, 1'b0, DW'(0),    1'b1};
        tbl[15] = '{1'b1, DW'('h11), 1'b0, 1'b0, 1'b1, DW'('h11), 1'b1};
        tbl[16] = '{1'b1, DW'('h22), 1'b0, 1'b0, 1'b1, DW'('h11), 1'b0};
        tbl[17] = '{1'b1, DW'('hD),  1'b0, 1'b1, 1'b0, DW'(0),    1'b1};
        tbl[18] = '{1'b1, DW'('hE),  1'b0, 1'b0, 1'b1, DW'('hE),  1'b1};
        tbl[19] = '{1'b0, DW'(0),    1'b1, 1'b0, 1'b0, DW'(0),    1'b1};
        tbl[20] = '{1'b1, DW'('h33), 1'b1, 1'b1, 1'b0, DW'(0),    1'b1};

        rst = 1'b1;
        flush = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_a.in_data = '0;
        bus_a.out_ready = 1'b0;
        #2;
        chk("reset_out_valid", DW'(bus_a.out_valid), '0);
        chk("reset_out_data",  bus_a.out_data,       '0);
        chk("reset_in_ready",  DW'(bus_a.in_ready),  DW'(1));
        chk_cnt("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].e_ov);
            chk($sformatf("v%0d_out_valid", i), DW'(bus_a.out_valid), DW'(tbl[i].e_ov));
            chk($sformatf("v%0d_out_data", i),  bus_a.out_data,       tbl[i].e_od);
            chk($sformatf("v%0d_in_ready", i),  DW'(bus_a.in_ready),  DW'(tbl[i].e_ir));
            chk($sformatf("v%0d_b_out_data", i), bus_b.out_data,      tbl[i].e_od);
        end
        chk_cnt("table");

        // Asynchronous reset while holding two entries
        drive(1'b1, DW'('h11), 1'b0, 1'b0, 1'b1);
        drive(1'b1, DW'('h22), 1'b0, 1'b0, 1'b1);
        chk("two_in_ready", DW'(bus_a.in_ready), '0);
        chk("two_out_data", bus_a.out_data, DW'('h11));
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_out_valid", DW'(bus_a.out_valid), '0);
        chk("arst_out_data",  bus_a.out_data,       '0);
        chk("arst_in_ready",  DW'(bus_a.in_ready),  DW'(1));
        chk("arst_stall",     DW'(stall_a),         '0);
        chk("arst_bubble",    DW'(bubble_a),        '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_stall = 0; m_bubble = 0; m_stall2 = 0; m_bubble2 = 0;
        prev_ov = 1'b0;

        // Counter scenario: 5 stall cycles then 3 bubble cycles
        drive(1'b1, DW'(5), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, DW'(0), 1'b0, 1'b0, 1'b1);
        chk("cnt_held_data", bus_a.out_data, DW'(5));
        drive(1'b0, DW'(0), 1'b1, 1'b0, 1'b0);
        chk("cnt_popped_valid", DW'(bus_a.out_valid), '0);
        for (int i = 0; i < 3; i++) drive(1'b0, DW'(0), 1'b1, 1'b0, 1'b0);
        bus_a.out_ready = 1'b0;
        chk("cnt_stall32",  DW'(stall_a),  PERF ? DW'(5) : '0);
        chk("cnt_bubble32", DW'(bubble_a), PERF ? DW'(3) : '0);
        chk("cnt_stall2",   DW'(stall_b),  PERF ? DW'(3) : '0);
        chk("cnt_bubble2",  DW'(bubble_b), PERF ? DW'(3) : '0);

        // Flush keeps counters
        drive(1'b1, DW'(7), 1'b0, 1'b1, 1'b0);
        chk("flush_keep_valid", DW'(bus_a.out_valid), '0);
        chk("flush_keep_bubble", DW'(bubble_a), PERF ? DW'(3) : '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
